// File: rtl/ysyx_22040750_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040750_axi_pkg
//   Shared AXI encodings for the read slave: burst types, response codes,
//   the read-FSM state type and a helper that classifies unsupported AR
//   requests.
// ---------------------------------------------------------------------------
package ysyx_22040750_axi_pkg;

    typedef enum logic [1:0] {
        AXI_FIXED = 2'b00,
        AXI_INCR  = 2'b01,
        AXI_WRAP  = 2'b10,
        AXI_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    // Largest supported beat size exponent (8 bytes per beat).
    localparam logic [2:0] AXI_MAX_SIZE = 3'd3;

    // A request is answered with SLVERR when the beat is wider than the bus,
    // the burst type is reserved, or a WRAP length is not 2/4/8/16 beats.
    function automatic logic ar_is_bad(input logic [7:0]  len,
                                       input logic [2:0]  size,
                                       input axi_burst_e  burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > AXI_MAX_SIZE) ||
               (burst == AXI_RSVD) ||
               ((burst == AXI_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/ysyx_22040750_rfifo2.sv
// ---------------------------------------------------------------------------
// ysyx_22040750_rfifo2
//   Two-entry response buffer between the memory read port and the AXI
//   R channel.
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     push_i, wdata_i    write one entry
//     pop_i              remove the head entry
//     rdata_o            head entry (valid while empty_o = 0)
//     full_o, empty_o    occupancy flags
// ---------------------------------------------------------------------------
module ysyx_22040750_rfifo2 #(
    parameter int unsigned WIDTH = 67
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       cnt_q,  cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign rdata_o = mem_q[rptr_q];

    // A push into a full buffer is allowed when the head leaves in the same
    // cycle: the write lands in the slot being vacated.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);

    always_comb begin
        wptr_d = wptr_q ^ push_ok;
        rptr_d = rptr_q ^ pop_ok;
        cnt_d  = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata_i;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_22040750_axi_rd_slave.sv
// ---------------------------------------------------------------------------
// ysyx_22040750_axi_rd_slave
//   AXI4 read-only slave in front of a single-cycle-latency memory port.
//   One burst at a time; FIXED/INCR/WRAP addressing; unsupported requests
//   return SLVERR beats without touching memory.
//   Ports:
//     I_clk, I_rst_n           clock, asynchronous active-low reset
//     I_axi_ar* / O_axi_arready AR channel
//     O_axi_r* / I_axi_rready   R channel
//     O_mem_addr, O_mem_ren     8-byte aligned read request
//     I_mem_rdata               read data, one cycle after O_mem_ren
// ---------------------------------------------------------------------------
module ysyx_22040750_axi_rd_slave
    import ysyx_22040750_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic [ADDR_W-1:0] I_axi_araddr,
    input  logic              I_axi_arvalid,
    output logic              O_axi_arready,
    input  logic [7:0]        I_axi_arlen,
    input  logic [2:0]        I_axi_arsize,
    input  logic [1:0]        I_axi_arburst,
    output logic [DATA_W-1:0] O_axi_rdata,
    output logic [1:0]        O_axi_rresp,
    output logic              O_axi_rvalid,
    output logic              O_axi_rlast,
    input  logic              I_axi_rready,
    output logic [ADDR_W-1:0] O_mem_addr,
    output logic              O_mem_ren,
    input  logic [DATA_W-1:0] I_mem_rdata
);

    // Buffer entry: {data, resp, last}
    localparam int unsigned ENT_W = DATA_W + 3;

    rd_state_e         state_q,     state_d;
    logic              arready_q,   arready_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [7:0]        len_q,       len_d;
    logic [2:0]        size_q,      size_d;
    axi_burst_e        burst_q,     burst_d;
    logic              err_q,       err_d;
    logic [7:0]        icnt_q,      icnt_d;
    logic              idone_q,     idone_d;
    logic              infl_q,      infl_d;
    logic              infl_last_q, infl_last_d;

    logic              ar_hs, r_hs, issue, out_valid;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2:0]        occ;
    logic [ENT_W-1:0]  byp_ent, head_ent, out_ent;
    axi_resp_e         beat_resp;
    logic [ADDR_W-1:0] beat_bytes, wrap_mask, addr_inc, addr_next;

    assign ar_hs = arready_q && I_axi_arvalid;

    // ---------------- beat address generation ----------------
    always_comb begin
        beat_bytes = ADDR_W'(1) << size_q;
        wrap_mask  = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        addr_inc   = addr_q + beat_bytes;
        addr_next  = addr_q;
        case (burst_q)
            AXI_INCR: addr_next = addr_inc;
            AXI_WRAP: addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default:  addr_next = addr_q;
        endcase
    end

    // ---------------- response path ----------------
    // Beats in the buffer plus the read whose data returns this cycle; a new
    // read is only issued while that total is below the buffer depth.
    assign occ = {1'b0, fifo_full, !fifo_empty && !fifo_full} + {2'b00, infl_q};

    assign beat_resp = err_q ? AXI_SLVERR : AXI_OKAY;
    assign byp_ent   = {(err_q ? {DATA_W{1'b0}} : I_mem_rdata), beat_resp, infl_last_q};

    // Returning data goes straight to the R channel when the buffer is empty;
    // it is captured into the buffer only if the master does not take it, and
    // from then on the buffer head presents the same value.
    assign out_ent   = fifo_empty ? byp_ent : head_ent;
    assign out_valid = (state_q == BURST) && (!fifo_empty || infl_q);
    assign r_hs      = out_valid && I_axi_rready;
    assign fifo_pop  = !fifo_empty && I_axi_rready;
    assign fifo_push = infl_q && !(fifo_empty && I_axi_rready);

    ysyx_22040750_rfifo2 #(
        .WIDTH (ENT_W)
    ) u_rfifo (
        .clk_i   (I_clk),
        .rst_ni  (I_rst_n),
        .push_i  (fifo_push),
        .wdata_i (byp_ent),
        .pop_i   (fifo_pop),
        .rdata_o (head_ent),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        err_d       = err_q;
        icnt_d      = icnt_q;
        idone_d     = idone_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d = BURST;
                    addr_d  = I_axi_araddr;
                    len_d   = I_axi_arlen;
                    size_d  = I_axi_arsize;
                    burst_d = axi_burst_e'(I_axi_arburst);
                    err_d   = ar_is_bad(I_axi_arlen, I_axi_arsize, axi_burst_e'(I_axi_arburst));
                    icnt_d  = '0;
                    idone_d = 1'b0;
                end
            end
            BURST: begin
                // Error bursts step through the same issue slots so beat
                // timing is identical; only the memory strobe is suppressed.
                if (!idone_q && (occ < 3'd2)) begin
                    issue       = 1'b1;
                    infl_d      = 1'b1;
                    infl_last_d = (icnt_q == len_q);
                    idone_d     = (icnt_q == len_q);
                    icnt_d      = icnt_q + 8'd1;
                    addr_d      = addr_next;
                end
                if (r_hs && out_ent[0]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        arready_d = (state_d == IDLE);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= IDLE;
            arready_q   <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= AXI_FIXED;
            err_q       <= 1'b0;
            icnt_q      <= '0;
            idone_q     <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arready_q   <= arready_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
            icnt_q      <= icnt_d;
            idone_q     <= idone_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    // ---------------- outputs ----------------
    assign O_axi_arready = arready_q;
    assign O_axi_rvalid  = out_valid;
    assign O_axi_rdata   = out_valid ? out_ent[ENT_W-1:3] : '0;
    assign O_axi_rresp   = out_valid ? out_ent[2:1] : 2'b00;
    assign O_axi_rlast   = out_valid && out_ent[0];
    assign O_mem_ren     = issue && !err_q;
    assign O_mem_addr    = {addr_q[ADDR_W-1:3], 3'b000};

endmodule

// File: tb/tb_ysyx_22040750_axi_rd_slave.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040750_axi_rd_slave
//   Self-checking bench for the AXI read slave: directed scenarios plus
//   randomized bursts compared against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_ysyx_22040750_axi_rd_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic [63:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    ysyx_22040750_axi_rd_slave #(
        .ADDR_W (32),
        .DATA_W (64)
    ) dut (
        .I_clk         (clk),
        .I_rst_n       (rst_n),
        .I_axi_araddr  (araddr),
        .I_axi_arvalid (arvalid),
        .O_axi_arready (arready),
        .I_axi_arlen   (arlen),
        .I_axi_arsize  (arsize),
        .I_axi_arburst (arburst),
        .O_axi_rdata   (rdata),
        .O_axi_rresp   (rresp),
        .O_axi_rvalid  (rvalid),
        .O_axi_rlast   (rlast),
        .I_axi_rready  (rready),
        .O_mem_addr    (mem_addr),
        .O_mem_ren     (mem_ren),
        .I_mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5A5A_C3C3, ~a};
    endfunction

    // Memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem_word(mem_addr);
        else         mem_rdata <= {$urandom, $urandom};
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [63:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    logic        exp_last[$];
    logic [31:0] exp_maddr[$];

    function automatic bit model_err(input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        return (s > 3) || (b == 2'b11) ||
               (b == 2'b10 && !(l == 1 || l == 3 || l == 7 || l == 15));
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [7:0] l,
                                               input logic [2:0] s, input logic [1:0] b, input int i);
        logic [31:0] bytes, wsize, base;
        bytes = 32'd1 << s;
        wsize = (32'(l) + 1) * bytes;
        case (b)
            2'b01:   return a + 32'(i) * bytes;
            2'b10: begin
                base = (a / wsize) * wsize;
                return base + ((a - base) + 32'(i) * bytes) % wsize;
            end
            default: return a;
        endcase
    endfunction

    task automatic build_expect(input logic [31:0] a, input logic [7:0] l,
                                input logic [2:0] s, input logic [1:0] b);
        bit          err;
        logic [31:0] ad;
        exp_data.delete(); exp_resp.delete(); exp_last.delete(); exp_maddr.delete();
        err = model_err(l, s, b);
        for (int i = 0; i <= int'(l); i++) begin
            ad = model_addr(a, l, s, b, i);
            exp_data.push_back(err ? 64'd0 : mem_word(ad & ~32'h7));
            exp_resp.push_back(err ? 2'b10 : 2'b00);
            exp_last.push_back(i == int'(l));
            if (!err) exp_maddr.push_back(ad & ~32'h7);
        end
    endtask

    // ---------------- burst driver / monitor ----------------
    logic [63:0] obs_data[$];
    logic [1:0]  obs_resp[$];
    logic        obs_last[$];
    logic [31:0] obs_maddr[$];
    int          obs_hsk[$];
    int          obs_first_lat, obs_max_out, obs_stall_err, obs_ar_wait, obs_ar_in_burst;
    bit          obs_timeout;

    // rmode: 0 = rready always 1, 1 = 1,0,0 pattern over valid cycles, 2 = random
    task automatic do_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, input int rmode, input bit hold_next,
                            input logic [31:0] na, input logic [7:0] nl,
                            input logic [2:0] ns, input logic [1:0] nb);
        int          k, ren_tot, hs_tot, budget, pat;
        bit          prev_stall, done;
        logic [66:0] prev_out;
        obs_data.delete(); obs_resp.delete(); obs_last.delete(); obs_maddr.delete(); obs_hsk.delete();
        obs_timeout = 0; obs_ar_wait = 0; obs_first_lat = -1; obs_max_out = 0;
        obs_stall_err = 0; obs_ar_in_burst = 0;
        @(negedge clk);
        araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
        while (arready !== 1'b1) begin
            obs_ar_wait++;
            if (obs_ar_wait > 20) begin
                obs_timeout = 1; arvalid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        budget = (int'(l) + 1) * 4 + 20;
        ren_tot = 0; hs_tot = 0; pat = 0; prev_stall = 0; done = 0; k = 0; prev_out = '0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                arvalid = hold_next;
                if (hold_next) begin
                    araddr = na; arlen = nl; arsize = ns; arburst = nb;
                end
            end
            if (arready === 1'b1) obs_ar_in_burst++;
            if (mem_ren === 1'b1) begin
                ren_tot++;
                obs_maddr.push_back(mem_addr);
            end
            if (ren_tot - hs_tot > obs_max_out) obs_max_out = ren_tot - hs_tot;
            if (prev_stall && (rvalid !== 1'b1 || {rdata, rresp, rlast} !== prev_out))
                obs_stall_err++;
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = rvalid ? (pat % 3 == 0) : 1'b1;
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (rvalid === 1'b1) pat++;
            if (rvalid === 1'b1 && obs_first_lat < 0) obs_first_lat = k;
            if (rvalid === 1'b1 && rready) begin
                obs_data.push_back(rdata);
                obs_resp.push_back(rresp);
                obs_last.push_back(rlast);
                obs_hsk.push_back(k);
                hs_tot++;
                if (rlast === 1'b1) done = 1;
            end
            prev_stall = (rvalid === 1'b1) && !rready;
            prev_out   = {rdata, rresp, rlast};
        end
        if (!done) obs_timeout = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; arvalid = 1'b1; rready = 1'b1;
        araddr = 32'h8000_0000; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
        #12;
        tests++;
        if ({arready, rvalid, rlast, rresp, rdata, mem_ren, mem_addr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: arready=%b rvalid=%b rlast=%b rresp=%b rdata=%h ren=%b maddr=%h want all 0",
                     arready, rvalid, rlast, rresp, rdata, mem_ren, mem_addr);
        end
        @(negedge clk); arvalid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (arready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_arready: got %b want 1", arready);
        end
    endtask

    task automatic test_icache_fill();
        logic [31:0] want [4] = '{32'h8000_0020, 32'h8000_0028, 32'h8000_0030, 32'h8000_0038};
        build_expect(32'h8000_0020, 8'd3, 3'd3, 2'b01);
        do_burst(32'h8000_0020, 8'd3, 3'd3, 2'b01, 0, 0, '0, '0, '0, '0);
        tests++;
        if (obs_timeout !== 0) begin fails++; $display("FAIL icache_timeout: got %0d want 0", obs_timeout); end
        tests++;
        if (obs_maddr.size() != 4) begin fails++; $display("FAIL icache_ren_count: got %0d want 4", obs_maddr.size()); end
        for (int i = 0; i < 4 && i < obs_maddr.size(); i++) begin
            tests++;
            if (obs_maddr[i] !== want[i]) begin
                fails++; $display("FAIL icache_maddr%0d: got %h want %h", i, obs_maddr[i], want[i]);
            end
        end
        tests++;
        if (obs_data.size() != 4) begin fails++; $display("FAIL icache_beats: got %0d want 4", obs_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            tests++;
            if ({obs_data[i], obs_resp[i], obs_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
                fails++;
                $display("FAIL icache_beat%0d: got %h/%b/%b want %h/%b/%b", i, obs_data[i], obs_resp[i],
                         obs_last[i], exp_data[i], exp_resp[i], exp_last[i]);
            end
            tests++;
            if (obs_hsk[i] != 2 + i) begin
                fails++; $display("FAIL icache_cycle%0d: got %0d want %0d", i, obs_hsk[i], 2 + i);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [4] = '{32'h8000_0030, 32'h8000_0038, 32'h8000_0020, 32'h8000_0028};
        build_expect(32'h8000_0030, 8'd3, 3'd3, 2'b10);
        do_burst(32'h8000_0030, 8'd3, 3'd3, 2'b10, 0, 0, '0, '0, '0, '0);
        tests++;
        if (obs_maddr.size() != 4 || obs_timeout) begin
            fails++; $display("FAIL wrap_ren_count: got %0d (timeout %0d) want 4", obs_maddr.size(), obs_timeout);
        end
        for (int i = 0; i < 4 && i < obs_maddr.size(); i++) begin
            tests++;
            if (obs_maddr[i] !== want[i]) begin
                fails++; $display("FAIL wrap_maddr%0d: got %h want %h", i, obs_maddr[i], want[i]);
            end
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            tests++;
            if ({obs_data[i], obs_resp[i], obs_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
                fails++;
                $display("FAIL wrap_beat%0d: got %h/%b/%b want %h/%b/%b", i, obs_data[i], obs_resp[i],
                         obs_last[i], exp_data[i], exp_resp[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        build_expect(32'h8000_0100, 8'd3, 3'd3, 2'b01);
        do_burst(32'h8000_0100, 8'd3, 3'd3, 2'b01, 1, 0, '0, '0, '0, '0);
        tests++;
        if (obs_data.size() != 4 || obs_timeout) begin
            fails++; $display("FAIL bp_beats: got %0d (timeout %0d) want 4", obs_data.size(), obs_timeout);
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            tests++;
            if ({obs_data[i], obs_resp[i], obs_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
                fails++;
                $display("FAIL bp_beat%0d: got %h/%b/%b want %h/%b/%b", i, obs_data[i], obs_resp[i],
                         obs_last[i], exp_data[i], exp_resp[i], exp_last[i]);
            end
        end
        tests++;
        if (obs_stall_err != 0) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", obs_stall_err); end
        tests++;
        if (obs_max_out > 2) begin fails++; $display("FAIL bp_inflight: got %0d want <=2", obs_max_out); end
        tests++;
        if (obs_maddr.size() != 4) begin fails++; $display("FAIL bp_ren_count: got %0d want 4", obs_maddr.size()); end
    endtask

    task automatic test_error();
        build_expect(32'h8000_0040, 8'd1, 3'd4, 2'b01);
        do_burst(32'h8000_0040, 8'd1, 3'd4, 2'b01, 0, 0, '0, '0, '0, '0);
        tests++;
        if (obs_data.size() != 2 || obs_timeout) begin
            fails++; $display("FAIL err_beats: got %0d (timeout %0d) want 2", obs_data.size(), obs_timeout);
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            tests++;
            if ({obs_data[i], obs_resp[i], obs_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
                fails++;
                $display("FAIL err_beat%0d: got %h/%b/%b want %h/%b/%b", i, obs_data[i], obs_resp[i],
                         obs_last[i], exp_data[i], exp_resp[i], exp_last[i]);
            end
        end
        tests++;
        if (obs_maddr.size() != 0) begin fails++; $display("FAIL err_no_ren: got %0d strobes want 0", obs_maddr.size()); end
    endtask

    task automatic test_reset_mid_burst();
        int w, stale;
        @(negedge clk);
        araddr = 32'h8000_0200; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01;
        arvalid = 1'b1; rready = 1'b1;
        w = 0;
        while (arready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        @(negedge clk); arvalid = 1'b0;
        w = 0;
        while (rvalid !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        tests++;
        if (rvalid !== 1'b1) begin fails++; $display("FAIL rst_mid_first_beat: rvalid got %b want 1", rvalid); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({arready, rvalid, rlast, rresp, rdata, mem_ren, mem_addr} !== '0) begin
            fails++;
            $display("FAIL rst_mid_outputs: arready=%b rvalid=%b rlast=%b rresp=%b rdata=%h ren=%b maddr=%h want all 0",
                     arready, rvalid, rlast, rresp, rdata, mem_ren, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (arready !== 1'b1) begin fails++; $display("FAIL rst_mid_arready: got %b want 1", arready); end
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (rvalid !== 1'b0 || mem_ren !== 1'b0) stale++;
        end
        tests++;
        if (stale != 0) begin fails++; $display("FAIL rst_mid_stale: got %0d active cycles want 0", stale); end
    endtask

    task automatic test_back_to_back();
        build_expect(32'h8000_1000, 8'd3, 3'd3, 2'b01);
        do_burst(32'h8000_1000, 8'd3, 3'd3, 2'b01, 0, 1, 32'h8000_2008, 8'd1, 3'd3, 2'b01);
        tests++;
        if (obs_data.size() != 4 || obs_timeout) begin
            fails++; $display("FAIL b2b_a_beats: got %0d (timeout %0d) want 4", obs_data.size(), obs_timeout);
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            tests++;
            if ({obs_data[i], obs_resp[i], obs_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
                fails++;
                $display("FAIL b2b_a_beat%0d: got %h/%b/%b want %h/%b/%b", i, obs_data[i], obs_resp[i],
                         obs_last[i], exp_data[i], exp_resp[i], exp_last[i]);
            end
        end
        tests++;
        if (obs_ar_in_burst != 0) begin fails++; $display("FAIL b2b_arready_in_burst: got %0d cycles want 0", obs_ar_in_burst); end
        build_expect(32'h8000_2008, 8'd1, 3'd3, 2'b01);
        do_burst(32'h8000_2008, 8'd1, 3'd3, 2'b01, 0, 0, '0, '0, '0, '0);
        tests++;
        if (obs_ar_wait != 0) begin fails++; $display("FAIL b2b_accept: got %0d wait cycles want 0", obs_ar_wait); end
        tests++;
        if (obs_first_lat != 2) begin fails++; $display("FAIL b2b_latency: got %0d want 2", obs_first_lat); end
        tests++;
        if (obs_data.size() != 2 || obs_timeout) begin
            fails++; $display("FAIL b2b_b_beats: got %0d (timeout %0d) want 2", obs_data.size(), obs_timeout);
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            tests++;
            if ({obs_data[i], obs_resp[i], obs_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
                fails++;
                $display("FAIL b2b_b_beat%0d: got %h/%b/%b want %h/%b/%b", i, obs_data[i], obs_resp[i],
                         obs_last[i], exp_data[i], exp_resp[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;
        logic [7:0]  wl [4] = '{8'd1, 8'd3, 8'd7, 8'd15};
        for (int n = 0; n < 24; n++) begin
            b = 2'($urandom_range(0, 3));
            s = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            if (b == 2'b10 && $urandom_range(0, 3) != 0) l = wl[$urandom_range(0, 3)];
            else                                          l = 8'($urandom_range(0, 20));
            a = 32'h8000_0000 | ($urandom & 32'h0000_FFF8);
            if (s <= 3) a = a | (32'($urandom_range(0, 7)) & ~((32'd1 << s) - 1) & 32'h7);
            build_expect(a, l, s, b);
            do_burst(a, l, s, b, 2, 0, '0, '0, '0, '0);
            tests++;
            if (obs_data.size() != exp_data.size() || obs_timeout) begin
                fails++;
                $display("FAIL rnd%0d_beats: got %0d (timeout %0d) want %0d (a=%h l=%0d s=%0d b=%0d)",
                         n, obs_data.size(), obs_timeout, exp_data.size(), a, l, s, b);
            end
            for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
                tests++;
                if ({obs_data[i], obs_resp[i], obs_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
                    fails++;
                    $display("FAIL rnd%0d_beat%0d: got %h/%b/%b want %h/%b/%b", n, i, obs_data[i], obs_resp[i],
                             obs_last[i], exp_data[i], exp_resp[i], exp_last[i]);
                end
            end
            tests++;
            if (obs_maddr.size() != exp_maddr.size()) begin
                fails++; $display("FAIL rnd%0d_ren_count: got %0d want %0d", n, obs_maddr.size(), exp_maddr.size());
            end
            for (int i = 0; i < exp_maddr.size() && i < obs_maddr.size(); i++) begin
                tests++;
                if (obs_maddr[i] !== exp_maddr[i]) begin
                    fails++; $display("FAIL rnd%0d_maddr%0d: got %h want %h", n, i, obs_maddr[i], exp_maddr[i]);
                end
            end
            tests++;
            if (obs_stall_err != 0 || obs_max_out > 2) begin
                fails++;
                $display("FAIL rnd%0d_flow: got stall changes %0d inflight %0d want 0 and <=2", n, obs_stall_err, obs_max_out);
            end
        end
    endtask

    initial begin
        mem_rdata = '0;
        test_reset();
        test_icache_fill();
        test_wrap();
        test_backpressure();
        test_error();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22040750_axi_rd_slave.md
YSYX_22040750_AXI_RD_SLAVE -- requirements
Module: ysyx_22040750_axi_rd_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 64: data beat width; 8 bytes per beat.
REQ-003 SHALL have port I_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port I_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have AR-channel ports: I_axi_araddr in ADDR_W; I_axi_arvalid in 1; O_axi_arready out 1; I_axi_arlen in 8; I_axi_arsize in 3; I_axi_arburst in 2.
REQ-006 SHALL have R-channel ports: O_axi_rdata out DATA_W; O_axi_rresp out 2; O_axi_rvalid out 1; O_axi_rlast out 1; I_axi_rready in 1.
REQ-007 SHALL have memory-port signals: O_mem_addr out ADDR_W, the 8B-aligned beat address; O_mem_ren out 1, read strobe; I_mem_rdata in DATA_W, valid exactly one cycle after O_mem_ren.

Function
REQ-008 SHALL use FSM states IDLE and BURST: IDLE->BURST on AR handshake; BURST->IDLE on the R handshake of the last beat.
REQ-009 SHALL drive O_axi_arready=1 only in IDLE, so exactly one burst is outstanding at a time.
REQ-010 SHALL latch araddr, arlen, arsize and arburst on the AR handshake.
REQ-011 SHALL produce arlen+1 beats per burst, counted by an 8-bit beat counter.
REQ-012 SHALL issue the first O_mem_ren in the cycle after the AR handshake, so the first O_axi_rvalid rises two cycles after the handshake.
REQ-013 SHALL buffer memory data in a 2-entry response FIFO.
REQ-014 SHALL assert O_mem_ren only when FIFO occupancy plus in-flight reads is below 2 and beats remain to issue.
REQ-015 SHALL sustain one beat per cycle while I_axi_rready is held high.
REQ-016 SHALL hold O_axi_rdata, rresp and rlast stable while O_axi_rvalid=1 and I_axi_rready=0.
REQ-017 SHALL compute beat addresses by burst type: FIXED (00) repeats the start address; INCR (01) adds 2^arsize per beat; WRAP (10) wraps within a (arlen+1)*2^arsize aligned window.
REQ-018 SHALL answer with SLVERR (2'b10), rdata=0 and the full arlen+1 beat count, with no O_mem_ren, when arsize>3, arburst=11, or WRAP has arlen not in {1,3,7,15}; otherwise rresp=OKAY.
REQ-019 SHALL set O_axi_rlast=1 only on beat number arlen (the last beat).
REQ-020 SHALL drive O_mem_addr as the beat address with bits [2:0] forced to zero.
REQ-021 SHALL ignore I_axi_arvalid in BURST.
REQ-022 SHALL accept a new AR handshake in the cycle after the last R handshake (back-to-back bursts).

Reset
REQ-023 SHALL, while I_rst_n=0, immediately drive O_axi_arready=0, O_axi_rvalid=0, O_axi_rlast=0, O_axi_rresp=0, O_axi_rdata=0, O_mem_ren=0, O_mem_addr=0, and force state IDLE with the FIFO and counters cleared.
REQ-024 SHALL drop any burst in progress when reset asserts, with no further beats after deassertion.
REQ-025 SHALL assert O_axi_arready=1 in the first clock edge's cycle after I_rst_n deasserts.

Structure
REQ-026 SHALL define the AXI burst and resp encodings (FIXED/INCR/WRAP, OKAY/SLVERR) and the FSM state encoding in a shared package, ysyx_22040750_axi_pkg.
REQ-027 SHALL implement the response buffer as one sub-module, ysyx_22040750_rfifo2: 2 entries, width DATA_W+3, with full/empty flags.

Verification
REQ-028 SHALL cover icache-style fill: araddr=0x80000020, arlen=3, arsize=3, INCR, rready=1 -> mem addrs 0x20,0x28,0x30,0x38 (upper bits 0x800000), four consecutive rvalid cycles, rlast on the 4th, OKAY.
REQ-029 SHALL cover WRAP: araddr=0x80000030, arlen=3, arsize=3 -> beat addresses 0x30,0x38,0x20,0x28.
REQ-030 SHALL cover backpressure: rready toggling 1,0,0,1,... during a 4-beat burst -> no lost or duplicated beat, data stable while stalled, never more than 2 reads in flight.
REQ-031 SHALL cover error: arsize=4, arlen=1 -> two beats with rresp=2'b10 and rdata=0, rlast on beat 2, O_mem_ren never asserted.
REQ-032 SHALL cover reset mid-burst: I_rst_n low after beat 1 of 4 -> all outputs 0 at once; after release arready=1 and no stale beats.
REQ-033 SHALL cover back-to-back bursts: second arvalid held high during burst 1 -> accepted the cycle after burst 1's last handshake.
